uart_tx_frame_gen: RTL and testbench
====================================

Name: uart_tx_frame_gen

Overview:
Parametrised UART transmit framer that merges the serializer, parity generator, bit-select mux and frame FSM into one registered block. It accepts a parallel word through a valid/ready handshake. It emits start bit, LSB-first data, optional parity and 1 or 2 stop bits on TX_OUT, with a runtime-programmable bit period. It sits between the system-side register interface and the UART pad.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9 legal)
PRESCALE_W, 16, width of the PRESCALE bit-period input
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
P_DATA  input  DATA_WIDTH  parallel word to send
DATA_VALID  input  1  P_DATA valid
DATA_READY  output  1  block can accept a word this cycle
PAR_EN  input  1  1 = parity bit inserted
PAR_TYP  input  1  0 = even, 1 = odd
PRESCALE  input  PRESCALE_W  CLK cycles per bit; 0 treated as 1
TX_OUT  output  1  serial line, registered, idles high
BUSY  output  1  frame in progress

Behaviour:
- Reset (sync, RST=1 at edge): state=IDLE, TX_OUT=1, BUSY=0, DATA_READY=1, all counters and the shift register cleared. Reset mid-frame aborts the frame; TX_OUT returns to 1 at that edge with no partial-frame completion.
- Accept: DATA_VALID=1 and DATA_READY=1 at an edge. P_DATA, PAR_EN, PAR_TYP and PRESCALE are latched. Later changes to these inputs do not affect the frame in flight.
- DATA_READY = (state==IDLE) or (state==STOP and final stop bit and bit counter at last cycle). DATA_READY is combinational from state/counters only and does not depend on DATA_VALID.
- FSM: IDLE -> START on accept. START -> DATA after 1 bit period. DATA -> PARITY after DATA_WIDTH bits if latched PAR_EN=1, else DATA -> STOP. PARITY -> STOP after 1 bit period. STOP -> IDLE after STOP_BITS bit periods, or STOP -> START on an accept in the final cycle (back-to-back, zero idle gap).
- TX_OUT by state: IDLE 1, START 0, DATA shift_reg[0] (LSB first, shift right each bit), PARITY ^data XOR PAR_TYP, STOP 1.
- TX_OUT is registered. The first start-bit cycle on the line is the cycle after the accept edge. Each bit is held exactly max(PRESCALE,1) CLK cycles.
- Frame length in bit periods: 1 + DATA_WIDTH + PAR_EN + STOP_BITS.
- BUSY = 1 in every state except IDLE. BUSY stays high across back-to-back frames.
- Bit-period counter: PRESCALE_W bits, counts 0..P-1 and wraps. No overflow is possible because P <= 2^PRESCALE_W-1.
- Simultaneous DATA_VALID with RST: reset wins; the word is not accepted.

Optional Feature:
Macro UART_TX_BREAK_EN.
- When defined: adds input BREAK_REQ (1 bit). While in IDLE with BREAK_REQ=1, the FSM enters BREAK, drives TX_OUT=0, and holds BUSY=1 and DATA_READY=0. On BREAK_REQ deassertion it drives 1 for one bit period (mark-after-break) and then returns to IDLE. BREAK_REQ asserted mid-frame is ignored until IDLE.
- When not defined: no BREAK_REQ port and no BREAK state. Behaviour is exactly as above.

Test Plan:
- Reset then idle -> TX_OUT=1, BUSY=0, DATA_READY=1 for 20 cycles.
- PRESCALE=4, PAR_EN=0, P_DATA=8'hA5, 1 stop -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each level 4 cycles (40 cycles), then BUSY=0 on the next cycle.
- PRESCALE=1, PAR_EN=1, PAR_TYP=0, P_DATA=8'h07 -> parity bit=1. PAR_TYP=1 -> parity bit=0. Frame is 11 cycles.
- Back-to-back: DATA_VALID held high with words 8'h01 then 8'h80, PRESCALE=2 -> second start bit follows the first stop bit immediately, BUSY never drops, exactly 2 accepts.
- RST pulsed during DATA bit 3 -> TX_OUT=1 and BUSY=0 the next cycle. A new word sent afterwards produces a clean frame.
- PRESCALE=0 -> behaves identically to PRESCALE=1. Under UART_TX_BREAK_EN: BREAK_REQ held 30 cycles -> TX_OUT=0 for 30 cycles, then 1 for one bit period, then IDLE.

Source files
------------

// File: rtl/uart_tx_frame_gen.sv
// UART transmit framer: start, LSB-first data, optional parity, STOP_BITS stop bits; UART_TX_BREAK_EN adds line break.
// Latency: first start-bit cycle appears on o_tx_out the cycle after the accept edge; each bit lasts max(PRESCALE,1) clocks.
// Backpressure: o_data_ready is high in IDLE and in the last cycle of the final stop bit, so back-to-back frames have no gap.
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    input  logic [PRESCALE_W-1:0] i_prescale,
`ifdef UART_TX_BREAK_EN
    input  logic                  i_break_req,
`endif
    output logic                  o_tx_out,
    output logic                  o_busy
);

    localparam int BIT_W = 4;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MAB} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

    state_t                r_state, w_state_nxt;
    logic [PRESCALE_W-1:0] r_cnt, w_cnt_nxt;
    logic [BIT_W-1:0]      r_bit, w_bit_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [PRESCALE_W-1:0] r_pre;
    logic                  r_par;
    logic                  r_par_en;
    logic                  r_tx, w_tx_nxt;

    logic [PRESCALE_W-1:0] w_p;
    logic                  w_last_cyc;
    logic                  w_idle_rdy;
    logic                  w_accept;

    assign w_p        = (r_pre == '0) ? PRESCALE_W'(1) : r_pre;
    assign w_last_cyc = (r_cnt == w_p - PRESCALE_W'(1));

`ifdef UART_TX_BREAK_EN
    assign w_idle_rdy = (r_state == S_IDLE) && !i_break_req;
`else
    assign w_idle_rdy = (r_state == S_IDLE);
`endif

    assign o_data_ready = w_idle_rdy ||
                          ((r_state == S_STOP) && (r_bit == BIT_W'(STOP_BITS - 1)) && w_last_cyc);
    assign w_accept     = o_data_ready && i_data_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_tx_out     = r_tx;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_last_cyc ? '0 : r_cnt + PRESCALE_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
`ifdef UART_TX_BREAK_EN
                if (i_break_req) begin
                    w_state_nxt = S_BREAK;
                end else
`endif
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_bit_nxt   = '0;
                end
            end
            S_START: begin
                if (w_last_cyc) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_last_cyc) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_last_cyc) begin
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = '0;
                end
            end
            S_STOP: begin
                if (w_last_cyc) begin
                    if (r_bit == BIT_W'(STOP_BITS - 1)) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = w_accept ? S_START : S_IDLE;
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (!i_break_req) begin
                    w_state_nxt = S_MAB;
                end
            end
            S_MAB: begin
                if (w_last_cyc) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase

        // New word is loaded here so the registered line sees bit 0 as soon as DATA starts.
        if (w_accept) begin
            w_shift_nxt = i_p_data;
        end

        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = r_par;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  w_tx_nxt = 1'b0;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_pre    <= '0;
            r_par    <= 1'b0;
            r_par_en <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            if (w_accept) begin
                r_pre    <= i_prescale;
                r_par    <= (^i_p_data) ^ i_par_typ;
                r_par_en <= i_par_en;
            end
`ifdef UART_TX_BREAK_EN
            if ((r_state == S_IDLE) && i_break_req) begin
                r_pre <= i_prescale;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen with default parameters (8 data bits, 1 stop bit).
module tb_uart_tx_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  p_data;
    logic        data_valid;
    logic        data_ready;
    logic        par_en;
    logic        par_typ;
    logic [15:0] prescale;
    logic        tx_out;
    logic        busy;
`ifdef UART_TX_BREAK_EN
    logic        break_req;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_frame_gen #(.DATA_WIDTH(8), .PRESCALE_W(16), .STOP_BITS(1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_p_data     (p_data),
        .i_data_valid (data_valid),
        .o_data_ready (data_ready),
        .i_par_en     (par_en),
        .i_par_typ    (par_typ),
        .i_prescale   (prescale),
`ifdef UART_TX_BREAK_EN
        .i_break_req  (break_req),
`endif
        .o_tx_out     (tx_out),
        .o_busy       (busy)
    );

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [15:0] pre;
        logic [11:0] frame;   // line bits, bit 0 = start bit
        int          nbits;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left on a falling edge with the DUT idle.
    task automatic run_vec(input vec_t v);
        int p;
        p = (v.pre == 16'd0) ? 1 : int'(v.pre);
        check({v.name, " ready_before"}, 32'(data_ready), 32'd1);
        p_data     = v.data;
        par_en     = v.par_en;
        par_typ    = v.par_typ;
        prescale   = v.pre;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        p_data     = ~v.data;
        par_en     = ~v.par_en;
        par_typ    = ~v.par_typ;
        prescale   = v.pre + 16'd5;
        for (int b = 0; b < v.nbits; b++) begin
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                check({v.name, " tx"}, 32'(tx_out), 32'(v.frame[b]));
                check({v.name, " busy"}, 32'(busy), 32'd1);
            end
        end
        @(negedge clk);
        check({v.name, " busy_after"}, 32'(busy), 32'd0);
        check({v.name, " tx_after"}, 32'(tx_out), 32'd1);
        check({v.name, " ready_after"}, 32'(data_ready), 32'd1);
    endtask

    initial begin
        logic [19:0] bb_exp;
        int          accepts;
        logic        acc_pending;

        vecs[0] = '{"a5_p4",   8'hA5, 1'b0, 1'b0, 16'd4, 12'h34A, 10};
        vecs[1] = '{"07_even", 8'h07, 1'b1, 1'b0, 16'd1, 12'h60E, 11};
        vecs[2] = '{"07_odd",  8'h07, 1'b1, 1'b1, 16'd1, 12'h40E, 11};
        vecs[3] = '{"00_p0",   8'h00, 1'b0, 1'b0, 16'd0, 12'h200, 10};
        vecs[4] = '{"ff_odd",  8'hFF, 1'b1, 1'b1, 16'd3, 12'h7FE, 11};
        vecs[5] = '{"3c_even", 8'h3C, 1'b1, 1'b0, 16'd2, 12'h478, 11};

        rst        = 1'b1;
        p_data     = 8'h00;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = 16'd1;
`ifdef UART_TX_BREAK_EN
        break_req  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle tx", 32'(tx_out), 32'd1);
            check("idle busy", 32'(busy), 32'd0);
            check("idle ready", 32'(data_ready), 32'd1);
        end

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back: valid held high across two words, P=2.
        bb_exp      = 20'hC0202;
        accepts     = 0;
        acc_pending = 1'b1;
        par_en      = 1'b0;
        par_typ     = 1'b0;
        prescale    = 16'd2;
        p_data      = 8'h01;
        data_valid  = 1'b1;
        for (int cyc = 0; cyc < 44; cyc++) begin
            @(posedge clk);
            if (acc_pending) accepts++;
            #1;
            if (accepts == 1) p_data = 8'h80;
            if (accepts >= 2) data_valid = 1'b0;
            @(negedge clk);
            if (cyc < 40) begin
                check("b2b tx", 32'(tx_out), 32'(bb_exp[cyc/2]));
                check("b2b busy", 32'(busy), 32'd1);
            end else begin
                check("b2b idle busy", 32'(busy), 32'd0);
                check("b2b idle tx", 32'(tx_out), 32'd1);
            end
            acc_pending = data_ready && data_valid;
        end
        check("b2b accepts", 32'(accepts), 32'd2);

        // Reset in the middle of data bit 3 of 8'hA5 at P=4.
        p_data     = 8'hA5;
        prescale   = 16'd4;
        par_en     = 1'b0;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("pre-reset data bit3", 32'(tx_out), 32'd0);
        check("pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset tx", 32'(tx_out), 32'd1);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset ready", 32'(data_ready), 32'd1);
        rst = 1'b0;
        run_vec(vecs[0]);

        // Reset together with a valid word: nothing is accepted.
        rst        = 1'b1;
        data_valid = 1'b1;
        p_data     = 8'h55;
        prescale   = 16'd1;
        @(negedge clk);
        rst        = 1'b0;
        data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst+valid busy", 32'(busy), 32'd0);
            check("rst+valid tx", 32'(tx_out), 32'd1);
        end

`ifdef UART_TX_BREAK_EN
        prescale  = 16'd3;
        break_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("break tx", 32'(tx_out), 32'd0);
            check("break busy", 32'(busy), 32'd1);
            check("break ready", 32'(data_ready), 32'd0);
        end
        break_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mab tx", 32'(tx_out), 32'd1);
            check("mab busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("post break busy", 32'(busy), 32'd0);
        check("post break ready", 32'(data_ready), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
